// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and segment constants for the multiplexed seven-segment scanner.
// Segment bit order is {a,b,c,d,e,f,g} with bit 6 = a, active high.
package seven_seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_digit_dec.sv
// BCD nibble to seven-segment pattern; codes 10-15 render as a dark digit.
module seg7_digit_dec
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-digit anti-ghost blanking.
// Define SEG_LZB_EN to compile in leading-zero blanking.
//
// state | meaning
// IDLE  | scan disabled, all outputs dark
// BLANK | BLANK_CYCLES dark clocks before the current digit lights
// SHOW  | current digit lit for dwell+1 clocks
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIV_W        = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [DIV_W-1:0]      dwell,
    output logic [N_DIGITS-1:0]   dig_en,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
    localparam int CNT_W = (DIV_W > BLK_W) ? DIV_W : BLK_W;
    localparam logic [CNT_W-1:0] BLK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    scan_state_e           r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIV_W-1:0]      r_dwell;
    logic [4*N_DIGITS-1:0] r_pending;
    logic [4*N_DIGITS-1:0] r_active;
    logic [N_DIGITS-1:0]   r_dig_en;
    logic [6:0]            r_seg;
    logic                  r_frame_done;

    scan_state_e           w_nxt_state;
    logic [IDX_W-1:0]      w_nxt_idx;
    logic [CNT_W-1:0]      w_nxt_cnt;
    logic [DIV_W-1:0]      w_nxt_dwell;
    logic [4*N_DIGITS-1:0] w_nxt_pending;
    logic [4*N_DIGITS-1:0] w_nxt_active;
    logic [N_DIGITS-1:0]   w_nxt_dig_en;
    logic [6:0]            w_nxt_seg;
    logic                  w_nxt_frame_done;
    logic [3:0]            w_nibble;
    logic [6:0]            w_dec_seg;
    logic                  w_lzb_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_dwell      <= '0;
            r_pending    <= '0;
            r_active     <= '0;
            r_dig_en     <= '0;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_cnt        <= w_nxt_cnt;
            r_dwell      <= w_nxt_dwell;
            r_pending    <= w_nxt_pending;
            r_active     <= w_nxt_active;
            r_dig_en     <= w_nxt_dig_en;
            r_seg        <= w_nxt_seg;
            r_frame_done <= w_nxt_frame_done;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_idx        = r_idx;
        w_nxt_cnt        = r_cnt;
        w_nxt_dwell      = r_dwell;
        w_nxt_active     = r_active;
        w_nxt_frame_done = 1'b0;
        w_nxt_pending    = load ? digits_in : r_pending;

        if (!en) begin
            w_nxt_state = ST_IDLE;
            w_nxt_idx   = '0;
            w_nxt_cnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state  = ST_BLANK;
                    w_nxt_idx    = '0;
                    w_nxt_cnt    = BLK_LOAD;
                    w_nxt_dwell  = dwell;
                    w_nxt_active = w_nxt_pending;
                end
                ST_BLANK: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = ST_SHOW;
                        w_nxt_cnt   = CNT_W'(r_dwell);
                    end else begin
                        w_nxt_cnt = r_cnt - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = ST_BLANK;
                        w_nxt_cnt   = BLK_LOAD;
                        w_nxt_dwell = dwell;
                        // Frame wrap is the only point where new digits become visible.
                        if (r_idx == IDX_LAST) begin
                            w_nxt_idx        = '0;
                            w_nxt_frame_done = 1'b1;
                            w_nxt_active     = w_nxt_pending;
                        end else begin
                            w_nxt_idx = r_idx + 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_idx   = '0;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_nxt_idx == IDX_W'(k)) w_nibble = w_nxt_active[4*k +: 4];
        end
    end

    seg7_digit_dec u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

`ifdef SEG_LZB_EN
    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic                w_run;
        logic [N_DIGITS-1:0] w_lead;
        w_run       = 1'b1;
        w_lead      = '0;
        w_lzb_blank = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            w_run     = w_run & (w_nxt_active[4*k +: 4] == 4'h0);
            w_lead[k] = w_run;
        end
        for (int k = 1; k < N_DIGITS; k++) begin
            if (w_nxt_idx == IDX_W'(k)) w_lzb_blank = w_lead[k];
        end
    end
`else
    assign w_lzb_blank = 1'b0;
`endif

    always_comb begin
        w_nxt_dig_en = '0;
        w_nxt_seg    = SEG_BLANK;
        if (w_nxt_state == ST_SHOW) begin
            w_nxt_dig_en = N_DIGITS'(1) << w_nxt_idx;
            if (!w_lzb_blank) w_nxt_seg = w_dec_seg;
        end
    end

    assign dig_en     = r_dig_en;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: directed scenarios then random load/enable/reset traffic,
// checked each clock against a time-position model of the scan.
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [15:0] dwell = 16'h0;
    logic [3:0]  dig_en;
    logic [6:0]  seg;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    bit          m_on;
    int          m_t;
    int          m_dwell;
    logic [15:0] m_pending;
    logic [15:0] m_active;
    logic [3:0]  e_dig_en;
    logic [6:0]  e_seg;
    logic        e_fd;

    seven_seg_scan_ctrl #(
        .N_DIGITS     (N),
        .DIV_W        (DW),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .dwell      (dwell),
        .dig_en     (dig_en),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_pattern(input logic [15:0] val, input int dig);
        logic [15:0] sh;
        logic [3:0]  nib;
        sh  = val >> (4 * dig);
        nib = sh[3:0];
`ifdef SEG_LZB_EN
        if (dig > 0 && sh == 16'h0) return 7'b0;
`endif
        if (nib > 4'd9) return 7'b0;
        return seg_tab[nib];
    endfunction

    task automatic model_reset();
        m_on      = 1'b0;
        m_t       = 0;
        m_dwell   = 0;
        m_pending = 16'h0;
        m_active  = 16'h0;
        e_dig_en  = 4'h0;
        e_seg     = 7'h0;
        e_fd      = 1'b0;
    endtask

    // Expected outputs follow from the clock count since the scan began.
    task automatic model_edge();
        logic [15:0] np;
        int slot, pos, dig;
        if (!rst_n) begin
            model_reset();
            return;
        end
        np       = load ? digits_in : m_pending;
        e_fd     = 1'b0;
        e_dig_en = 4'h0;
        e_seg    = 7'h0;
        if (!en) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            m_on     = 1'b1;
            m_t      = 0;
            m_dwell  = int'(dwell);
            m_active = np;
        end else begin
            m_t++;
            slot = BC + m_dwell + 1;
            if (m_t % (N * slot) == 0) begin
                e_fd     = 1'b1;
                m_active = np;
            end
            pos = m_t % slot;
            dig = (m_t / slot) % N;
            if (pos >= BC) begin
                e_dig_en = 4'(1 << dig);
                e_seg    = exp_pattern(m_active, dig);
            end
        end
        m_pending = np;
    endtask

    task automatic compare_outputs();
        check_eq("dig_en", 32'(dig_en), 32'(e_dig_en));
        check_eq("seg", 32'(seg), 32'(e_seg));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic wait_digit(input logic [3:0] pat, input string tag);
        for (int k = 0; k < 200 && dig_en !== pat; k++) cycle();
        check_eq(tag, 32'(dig_en), 32'(pat));
    endtask

    task automatic load_idle(input logic [15:0] val);
        en = 1'b0;
        load = 1'b1;
        digits_in = val;
        cycle();
        load = 1'b0;
        en = 1'b1;
    endtask

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_outputs();
        cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        int z;
        v = 16'($urandom);
        z = $urandom_range(0, 3);
        if (z > 0) v = v & (16'hFFFF >> (4 * z));
        return v;
    endfunction

    initial begin
        int t_first, t_second, r;
        model_reset();

        // Reset held with enable and a load: outputs stay dark.
        rst_n = 1'b0; en = 1'b1; dwell = 16'd2;
        repeat (2) cycle();
        load = 1'b1; digits_in = 16'h1234;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        en = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Basic scan of 0x1234 with dwell 2.
        load_idle(16'h1234);
        wait_digit(4'b0001, "wait_d0");
        check_eq("d0_seg_4", 32'(seg), 32'(7'b0110011));
        t_first = -1; t_second = -1;
        for (int k = 0; k < 100 && t_second < 0; k++) begin
            cycle();
            if (frame_done === 1'b1) begin
                if (t_first < 0) t_first = k;
                else t_second = k;
            end
        end
        check_eq("fd_period", 32'(t_second - t_first), 32'd28);

        // Load during digit 1 must not tear the current frame.
        wait_digit(4'b0010, "wait_d1");
        load = 1'b1; digits_in = 16'h5678;
        cycle();
        load = 1'b0;
        wait_digit(4'b1000, "wait_d3");
        check_eq("d3_seg_old", 32'(seg), 32'(7'b0110000));
        wait_digit(4'b0001, "wait_d0_new");
        check_eq("d0_seg_new", 32'(seg), 32'(7'b1111111));

        // Invalid nibble renders dark.
        load_idle(16'h00A0);
        wait_digit(4'b0010, "wait_inv");
        check_eq("inv_seg", 32'(seg), 32'(7'b0));

        // Leading zeros.
        load_idle(16'h0070);
        wait_digit(4'b0100, "wait_lz2");
`ifdef SEG_LZB_EN
        check_eq("lz_d2", 32'(seg), 32'(7'b0000000));
`else
        check_eq("lz_d2", 32'(seg), 32'(7'b1111110));
`endif
        wait_digit(4'b0010, "wait_lz1");
        check_eq("lz_d1", 32'(seg), 32'(7'b1110000));
        wait_digit(4'b0001, "wait_lz0");
        check_eq("lz_d0", 32'(seg), 32'(7'b1111110));

        // Enable drop mid-SHOW, then reset pulse mid-SHOW.
        wait_digit(4'b0100, "wait_drop");
        en = 1'b0;
        cycle();
        check_eq("drop_dark", 32'(dig_en), 32'd0);
        en = 1'b1;
        wait_digit(4'b0001, "restart_d0");
        wait_digit(4'b0100, "wait_rst");
        async_reset_pulse();
        wait_digit(4'b0001, "rst_restart_d0");

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                load = 1'b1;
                digits_in = rand_digits();
            end else if (r < 11) begin
                en = ~en;
                if (!en) dwell = 16'($urandom_range(0, 5));
            end else if (r == 11) begin
                async_reset_pulse();
            end
            cycle();
            load = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 Parameter DIV_W, default 16, width of the per-digit dwell count.
REQ-003 Parameter BLANK_CYCLES, default 4, anti-ghosting blank clocks per digit slot (>=1).
REQ-004 Ports: one clock; reset asynchronous, active-low; named clk and rst_n.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  scan enable; low forces idle, all outputs dark.
REQ-008 load  input  1  one-clock strobe capturing digits_in into the pending register.
REQ-009 digits_in  input  4*N_DIGITS  BCD nibbles; nibble 0 = least-significant digit.
REQ-010 dwell  input  DIV_W  SHOW-phase length minus one, sampled at each slot start.
REQ-011 dig_en  output  N_DIGITS  active-high one-hot digit select, all-zero when dark.
REQ-012 seg  output  7  active-high segments {a,b,c,d,e,f,g}, bit 6 = a.
REQ-013 frame_done  output  1  one-clock pulse at the end of the last digit's SHOW phase.

Function
REQ-014 FSM states IDLE, BLANK, SHOW; all outputs registered.
REQ-015 IDLE: dig_en=0, seg=0; en=1 moves to BLANK of digit 0 on the next clock, committing pending into the active register.
REQ-016 BLANK lasts exactly BLANK_CYCLES clocks with dig_en=0, seg=0, then SHOW.
REQ-017 SHOW lasts dwell+1 clocks (dwell=0 gives 1 clock); dig_en has the current digit's bit set, seg holds the decoded active nibble.
REQ-018 After SHOW, digit index increments and returns to BLANK; after digit N_DIGITS-1 it wraps to 0 and pulses frame_done.
REQ-019 Frame period = N_DIGITS*(BLANK_CYCLES+dwell+1) clocks for constant dwell.
REQ-020 Decode 0-9: 1111110,0110000,1101101,1111001,0110011,1011011,1011111,1110000,1111111,1111011.
REQ-021 Nibbles 10-15 decode to 0000000 (blank digit), never X.
REQ-022 Pending-to-active commit occurs only at frame wrap (no tearing within a frame).
REQ-023 load on the same clock as frame wrap commits digits_in directly to active.
REQ-024 Multiple loads within one frame: last one wins.
REQ-025 en dropping in any state: next clock IDLE, outputs dark, digit index cleared; pending preserved.

Reset
REQ-026 rst_n low: state IDLE, digit index 0, dwell counter 0, pending and active registers 0, dig_en=0, seg=0, frame_done=0, asynchronously.
REQ-027 Reset assertion mid-SHOW darkens outputs immediately; after release, scan restarts from BLANK of digit 0 once en=1.

Configuration
REQ-028 Macro SEG_LZB_EN compiles in leading-zero blanking.
REQ-029 With SEG_LZB_EN: zero nibbles above the most-significant nonzero nibble show seg=0 (dig_en still asserted, timing unchanged); digit 0 is never blanked.
REQ-030 Without SEG_LZB_EN: every nibble decodes per REQ-020/021.

Structure
REQ-031 Shared package holds FSM state enum, 7-bit segment-pattern constants for 0-9, and SEG_BLANK constant.
REQ-032 Combinational sub-module seg7_digit_dec (nibble in, 7-bit pattern out) is instantiated once on the active nibble.

Verification
REQ-033 Reset: hold rst_n=0 with en=1, load pulsed -> dig_en=0, seg=0, frame_done=0 throughout.
REQ-034 Scan: digits_in=0x1234, load, dwell=2, en=1 -> per digit 4 dark clocks then 3 clocks; digit0 dig_en=0001 seg=0110011, digit3 dig_en=1000 seg=0110000; frame_done every 28 clocks.
REQ-035 No tearing: load 0x5678 during digit1 SHOW -> remaining digits of that frame show 0x1234 values; next frame digit0 seg=1111111.
REQ-036 Invalid nibble: digits_in=0x00A0 -> digit1 slot dig_en=0010, seg=0000000.
REQ-037 LZB (SEG_LZB_EN): digits_in=0x0070 -> digits 3,2 seg=0000000, digit1 seg=1110000, digit0 seg=1111110; without macro digits 3,2 seg=1111110.
REQ-038 Disruption: drop en mid-SHOW of digit2 -> dark next clock; re-enable -> restart at digit0 BLANK; repeat with rst_n pulse -> same restart.
